// File: rtl/fb_pal_lookup.sv
// Palette lookup for the video path: 8-bit colour indices in, 32-bit ARGB out.
// Sync/blank/border sideband travels alongside the palette RAM read so the output stays aligned.
module fb_pal_lookup #(
   parameter int RAM_LATENCY = 2,
   parameter int IDX_WIDTH   = 8,
   parameter int BANK_WIDTH  = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            pix_valid_i,
   input  logic [IDX_WIDTH-1:0]            pix_idx_i,
   input  logic                            hsync_i,
   input  logic                            vsync_i,
   input  logic                            blank_i,
   input  logic                            border_i,
   input  logic [BANK_WIDTH-1:0]           bank_i,
   input  logic                            bypass_i,
   input  logic [31:0]                     border_color_i,
   output logic                            ram_en_o,
   output logic [BANK_WIDTH+IDX_WIDTH-1:0] ram_addr_o,
   input  logic [31:0]                     ram_dout_i,
   output logic [31:0]                     rgb_o,
   output logic                            valid_o,
   output logic                            hsync_o,
   output logic                            vsync_o,
   output logic                            blank_o,
   output logic [BANK_WIDTH-1:0]           bank_active_o,
   output logic                            bank_pending_o
);

   // state   | meaning
   // IDLE    | bank_i matches the active bank
   // PENDING | a new bank is requested, waiting for the next vsync rising edge
   typedef enum logic {IDLE, PENDING} bank_state_t;

   typedef struct packed {
      logic                 valid;
      logic                 hsync;
      logic                 vsync;
      logic                 blank;
      logic                 border;
      logic                 bypass;
      logic [IDX_WIDTH-1:0] idx;
   } sb_t;

   bank_state_t           bank_state;
   logic [BANK_WIDTH-1:0] bank_active;
   logic                  vsync_q;
   sb_t                   sb_q [RAM_LATENCY+1];
   sb_t                   sb_out;
   logic                  out_valid;

   assign bank_active_o  = bank_active;
   assign bank_pending_o = (bank_state == PENDING);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_state  <= IDLE;
         bank_active <= '0;
         vsync_q     <= 1'b0;
      end else begin
         vsync_q <= vsync_i;
         if (vsync_i && !vsync_q) begin
            bank_active <= bank_i;
            bank_state  <= IDLE;
         end else begin
            bank_state <= (bank_i != bank_active) ? PENDING : IDLE;
         end
      end
   end

   // S0: issue the read with the bank as it stood before any update on this same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_en_o   <= 1'b0;
         ram_addr_o <= '0;
      end else begin
         ram_en_o <= pix_valid_i & ~blank_i & ~border_i & ~bypass_i;
         if (pix_valid_i && !blank_i && !border_i && !bypass_i)
            ram_addr_o <= {bank_active, pix_idx_i};
      end
   end

   // Entry 0 is aligned with S0; the last entry is aligned with ram_dout_i
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= RAM_LATENCY; i++)
            sb_q[i] <= '0;
      end else begin
         sb_q[0] <= '{valid:  pix_valid_i,
                      hsync:  hsync_i,
                      vsync:  vsync_i,
                      blank:  blank_i,
                      border: border_i,
                      bypass: bypass_i,
                      idx:    pix_idx_i};
         for (int i = 1; i <= RAM_LATENCY; i++)
            sb_q[i] <= sb_q[i-1];
      end
   end

   assign sb_out    = sb_q[RAM_LATENCY];
   assign out_valid = sb_out.valid & ~sb_out.blank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_o   <= '0;
         valid_o <= 1'b0;
         hsync_o <= 1'b0;
         vsync_o <= 1'b0;
         blank_o <= 1'b0;
      end else begin
         valid_o <= out_valid;
         hsync_o <= sb_out.hsync;
         vsync_o <= sb_out.vsync;
         blank_o <= sb_out.blank;
         if (!out_valid)
            rgb_o <= '0;
         else if (sb_out.border)
            rgb_o <= border_color_i;
         else if (sb_out.bypass)
            rgb_o <= {8'hFF, sb_out.idx, sb_out.idx, sb_out.idx};
         else
            rgb_o <= ram_dout_i;
      end
   end

endmodule

// File: tb/tb_fb_pal_lookup.sv
// Bench for fb_pal_lookup: a reference model of the lookup plus directed vectors and random traffic.
module tb_fb_pal_lookup;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pix_valid_i, hsync_i, vsync_i, blank_i, border_i, bypass_i;
   logic [7:0]  pix_idx_i;
   logic [2:0]  bank_i;
   logic [31:0] border_color_i;
   logic        ram_en_o;
   logic [10:0] ram_addr_o;
   logic [31:0] ram_dout_i;
   logic [31:0] rgb_o;
   logic        valid_o, hsync_o, vsync_o, blank_o;
   logic [2:0]  bank_active_o;
   logic        bank_pending_o;

   fb_pal_lookup dut (
      .clk(clk), .rst_n(rst_n), .pix_valid_i(pix_valid_i), .pix_idx_i(pix_idx_i),
      .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_i(blank_i), .border_i(border_i),
      .bank_i(bank_i), .bypass_i(bypass_i), .border_color_i(border_color_i),
      .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_dout_i(ram_dout_i),
      .rgb_o(rgb_o), .valid_o(valid_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
      .blank_o(blank_o), .bank_active_o(bank_active_o), .bank_pending_o(bank_pending_o)
   );

   always #5 clk = ~clk;

   // Palette RAM: returns the zero-extended address two clocks after it is presented
   logic [31:0] ram_d1, ram_d2;
   always @(posedge clk) begin
      ram_d1 <= {21'h0, ram_addr_o};
      ram_d2 <= ram_d1;
   end
   assign ram_dout_i = ram_d2;

   typedef struct {
      logic       valid, hs, vs, blank, border, bypass;
      logic [7:0] idx;
      logic [2:0] bank;
   } rec_t;

   int    checks = 0;
   int    errors = 0;
   rec_t  pq[$];
   logic [2:0]  bank_m;
   logic        vs_prev_m, en_m, pend_m;
   logic [10:0] addr_m;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      rec_t z;
      z = '{default: '0};
      pq = {z, z, z};
      bank_m = '0; vs_prev_m = 1'b0; en_m = 1'b0; pend_m = 1'b0; addr_m = '0;
   endtask

   task automatic set_pix(input logic v, input logic [7:0] idx, input logic hs, input logic vs,
                          input logic bl, input logic bd, input logic bp);
      pix_valid_i = v; pix_idx_i = idx; hsync_i = hs; vsync_i = vs;
      blank_i = bl; border_i = bd; bypass_i = bp;
   endtask

   // One clock: advance the model with the inputs sampled on this edge, then compare all outputs
   task automatic step();
      rec_t r, o;
      logic        ev;
      logic [31:0] er;
      @(posedge clk);
      r = '{valid: pix_valid_i, hs: hsync_i, vs: vsync_i, blank: blank_i, border: border_i,
            bypass: bypass_i, idx: pix_idx_i, bank: bank_m};
      en_m = pix_valid_i & ~blank_i & ~border_i & ~bypass_i;
      if (en_m) addr_m = {bank_m, pix_idx_i};
      if (vsync_i && !vs_prev_m) bank_m = bank_i;
      vs_prev_m = vsync_i;
      pend_m = (bank_i != bank_m);
      pq.push_back(r);
      o = pq.pop_front();
      ev = o.valid & ~o.blank;
      if (!ev)           er = 32'h0;
      else if (o.border) er = border_color_i;
      else if (o.bypass) er = {8'hFF, o.idx, o.idx, o.idx};
      else               er = {21'h0, o.bank, o.idx};
      #1;
      check("rgb", rgb_o, er);
      check("valid", {31'h0, valid_o}, {31'h0, ev});
      check("hsync", {31'h0, hsync_o}, {31'h0, o.hs});
      check("vsync", {31'h0, vsync_o}, {31'h0, o.vs});
      check("blank", {31'h0, blank_o}, {31'h0, o.blank});
      check("ram_en", {31'h0, ram_en_o}, {31'h0, en_m});
      check("ram_addr", {21'h0, ram_addr_o}, {21'h0, addr_m});
      check("bank_active", {29'h0, bank_active_o}, {29'h0, bank_m});
      check("bank_pending", {31'h0, bank_pending_o}, {31'h0, pend_m});
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_rgb"}, rgb_o, 32'h0);
      check({nm, "_flags"}, {26'h0, valid_o, hsync_o, vsync_o, blank_o, ram_en_o, bank_pending_o}, 32'h0);
      check({nm, "_addr_bank"}, {18'h0, bank_active_o, ram_addr_o}, 32'h0);
   endtask

   typedef struct {
      logic        blank, border, bypass;
      logic [31:0] exp_rgb;
      logic        exp_valid, exp_en;
   } vec_t;
   vec_t vt[7];

   initial begin
      int         n;
      int         changes;
      logic [2:0] last_bank;
      logic       seen;

      vt[0] = '{0, 0, 0, 32'h0000057A, 1, 1};
      vt[1] = '{1, 0, 0, 32'h00000000, 0, 0};
      vt[2] = '{0, 1, 0, 32'h80112233, 1, 0};
      vt[3] = '{0, 0, 1, 32'hFF7A7A7A, 1, 0};
      vt[4] = '{0, 1, 1, 32'h80112233, 1, 0};
      vt[5] = '{1, 1, 1, 32'h00000000, 0, 0};
      vt[6] = '{1, 0, 1, 32'h00000000, 0, 0};

      rst_n = 1'b0;
      set_pix(0, 8'h00, 0, 0, 0, 0, 0);
      bank_i = 3'd0; border_color_i = 32'h80112233;
      model_reset();
      #12;
      check_all_zero("reset");
      #10 rst_n = 1'b1;

      // T1: back-to-back sweep in bank 0
      for (int i = 0; i < 256; i++) begin
         set_pix(1, i[7:0], 0, 0, 0, 0, 0);
         step();
      end
      set_pix(0, 8'h00, 0, 0, 0, 0, 0);
      repeat (4) step();

      // T2: bank request held off until vsync rises
      bank_i = 3'd5;
      for (int i = 0; i < 10; i++) begin
         set_pix(1, 8'h40 + i[7:0], 0, 0, 0, 0, 0);
         step();
         check("t2_addr_old_bank", {29'h0, ram_addr_o[10:8]}, 32'h0);
         check("t2_pending", {31'h0, bank_pending_o}, 32'h1);
      end
      set_pix(1, 8'h33, 0, 1, 0, 0, 0);
      step();
      check("t2_edge_pending", {31'h0, bank_pending_o}, 32'h0);
      set_pix(1, 8'h34, 0, 1, 0, 0, 0);
      step();
      check("t2_new_addr", {21'h0, ram_addr_o}, 32'h534);
      set_pix(0, 8'h00, 0, 0, 0, 0, 0);
      repeat (4) step();

      // T3: colour-select priority table
      for (int k = 0; k < 7; k++) begin
         set_pix(1, 8'h7A, 0, 0, vt[k].blank, vt[k].border, vt[k].bypass);
         step();
         check($sformatf("t3_en_%0d", k), {31'h0, ram_en_o}, {31'h0, vt[k].exp_en});
         set_pix(0, 8'h00, 0, 0, 0, 0, 0);
         repeat (3) step();
         check($sformatf("t3_rgb_%0d", k), rgb_o, vt[k].exp_rgb);
         check($sformatf("t3_valid_%0d", k), {31'h0, valid_o}, {31'h0, vt[k].exp_valid});
      end

      // T4: random traffic including sync/blank patterns and bank requests
      for (int i = 0; i < 300; i++) begin
         set_pix($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
         if ($urandom_range(0, 9) == 0) bank_i = 3'($urandom);
         border_color_i = $urandom;
         step();
      end
      set_pix(0, 8'h00, 0, 0, 0, 0, 0);
      border_color_i = 32'h80112233;
      repeat (4) step();

      // T5: reset in the middle of a streaming line
      for (int i = 0; i < 6; i++) begin
         set_pix(1, 8'h10 + i[7:0], 0, 0, 0, 0, 0);
         step();
      end
      #3 rst_n = 1'b0;
      #1 check_all_zero("t5_async");
      model_reset();
      set_pix(0, 8'h00, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b1;
      repeat (5) step();
      set_pix(1, 8'h21, 0, 0, 0, 0, 0);
      n = 0; seen = 1'b0;
      while (!seen && n < 10) begin
         step();
         n++;
         set_pix(0, 8'h00, 0, 0, 0, 0, 0);
         seen = valid_o;
      end
      check("t5_first_valid_latency", n, 4);
      repeat (4) step();

      // T6: top address, then vsync held high with bank_i toggling
      bank_i = 3'd7;
      set_pix(0, 8'h00, 0, 1, 0, 0, 0);
      step();
      set_pix(1, 8'hFF, 0, 1, 0, 0, 0);
      step();
      check("t6_addr_7ff", {21'h0, ram_addr_o}, 32'h7FF);
      set_pix(0, 8'h00, 0, 0, 0, 0, 0);
      step();
      bank_i = 3'd2;
      set_pix(0, 8'h00, 0, 1, 0, 0, 0);
      last_bank = bank_active_o;
      changes = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (bank_active_o != last_bank) changes++;
         last_bank = bank_active_o;
         bank_i = 3'($urandom);
      end
      check("t6_single_update", changes, 1);
      check("t6_bank_kept", {29'h0, bank_active_o}, 32'h2);
      set_pix(0, 8'h00, 0, 0, 0, 0, 0);
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
